video_timing_gen: RTL and testbench

Parametrised raster timing generator for the HDMI/VGA output path. Produces sync, data-enable, pixel coordinates and frame/line event pulses for any CVT-style mode set by parameters. Also produces a look-ahead fetch coordinate so framebuffer or character-ROM pipelines can issue reads a fixed number of pixels before display. Sits between the pixel-clock-enable source and the pixel pipeline / TMDS encoder.

---
 rtl/video_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: sync, data-enable, active coordinates, frame/line
// event pulses and a look-ahead fetch coordinate for a parameterised mode.
// The pixel position advances once per i_clk cycle in which i_pix_stb is high,
// and every output is registered from the position it lands on at that edge.
module video_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int LOOKAHEAD = 0,
    parameter int CW        = 12,
    parameter int FW        = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pix_stb,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_de,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic          o_vblank_start,
    output logic          o_fetch,
    output logic [CW-1:0] o_fx,
    output logic [CW-1:0] o_fy,
    output logic [FW-1:0] o_frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW:0]   LA_C    = (CW+1)'(LOOKAHEAD);
    localparam logic [CW:0]   H_TOT_W = (CW+1)'(H_TOTAL);
    localparam logic [FW-1:0] F_ONE   = FW'(1);
    localparam logic          HS_ON   = 1'(HS_POL);
    localparam logic          VS_ON   = 1'(VS_POL);

    // Decode the position LOOKAHEAD pixels ahead of (h, v) into
    // {active, x, y}; a lead past the line end lands on the next line.
    function automatic logic [2*CW:0] fetch_decode(input logic [CW-1:0] h,
                                                   input logic [CW-1:0] v);
        logic [CW:0]   p;
        logic [CW-1:0] ph;
        logic [CW-1:0] pv;
        logic          act;
        p = {1'b0, h} + LA_C;
        if (p >= H_TOT_W) begin
            ph = CW'(p - H_TOT_W);
            pv = (v == V_LAST) ? {CW{1'b0}} : (v + ONE_C);
        end else begin
            ph = p[CW-1:0];
            pv = v;
        end
        act = (ph < H_ACT_C) && (pv < V_ACT_C);
        return act ? {1'b1, ph, pv} : {1'b0, {CW{1'b0}}, {CW{1'b0}}};
    endfunction

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;
    logic          vbs_q, vbs_d;
    logic          fetch_q, fetch_d;
    logic [CW-1:0] fx_q, fx_d;
    logic [CW-1:0] fy_q, fy_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [2*CW:0] fetch_now;
    logic [2*CW:0] fetch_rst;

    // Next raster position: step on strobe, wrapping line then frame.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (i_pix_stb) begin
            if (h_q == H_LAST) begin
                h_d = {CW{1'b0}};
                v_d = (v_q == V_LAST) ? {CW{1'b0}} : (v_q + ONE_C);
            end else begin
                h_d = h_q + ONE_C;
                v_d = v_q;
            end
        end else begin
            h_d = h_q;
            v_d = v_q;
        end
    end

    // Decode the next position into level outputs, pulses and frame count.
    always_comb begin
        de_d      = (h_d < H_ACT_C) && (v_d < V_ACT_C);
        x_d       = de_d ? h_d : {CW{1'b0}};
        y_d       = de_d ? v_d : {CW{1'b0}};
        hs_d      = ((h_d >= HS_BEG) && (h_d < HS_END)) ? HS_ON : ~HS_ON;
        vs_d      = ((v_d >= VS_BEG) && (v_d < VS_END)) ? VS_ON : ~VS_ON;
        fetch_now = fetch_decode(h_d, v_d);
        fetch_rst = fetch_decode(H_LAST, V_LAST);
        fetch_d   = fetch_now[2*CW];
        fx_d      = fetch_now[2*CW-1:CW];
        fy_d      = fetch_now[CW-1:0];
        ls_d      = i_pix_stb && (h_d == {CW{1'b0}}) && (v_d < V_ACT_C);
        fs_d      = i_pix_stb && (h_d == {CW{1'b0}}) && (v_d == {CW{1'b0}});
        vbs_d     = i_pix_stb && (h_d == {CW{1'b0}}) && (v_d == V_ACT_C);
        frame_d   = fs_d ? (frame_q + F_ONE) : frame_q;
    end

    // State and output registers; reset parks on the last back-porch pixel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            hs_q    <= ~HS_ON;
            vs_q    <= ~VS_ON;
            de_q    <= 1'b0;
            x_q     <= {CW{1'b0}};
            y_q     <= {CW{1'b0}};
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            vbs_q   <= 1'b0;
            fetch_q <= fetch_rst[2*CW];
            fx_q    <= fetch_rst[2*CW-1:CW];
            fy_q    <= fetch_rst[CW-1:0];
            frame_q <= {FW{1'b0}};
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            vbs_q   <= vbs_d;
            fetch_q <= fetch_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            frame_q <= frame_d;
        end
    end

    assign o_hs           = hs_q;
    assign o_vs           = vs_q;
    assign o_de           = de_q;
    assign o_x            = x_q;
    assign o_y            = y_q;
    assign o_line_start   = ls_q;
    assign o_frame_start  = fs_q;
    assign o_vblank_start = vbs_q;
    assign o_fetch        = fetch_q;
    assign o_fx           = fx_q;
    assign o_fy           = fy_q;
    assign o_frame        = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (default 640x480 mode, a small
// mode with look-ahead 3, a tiny inverted-polarity mode with maximal
// look-ahead) compared every cycle against a linear-pixel-index model.
module tb_video_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
        logic        vbs;
        logic        fetch;
        logic [11:0] fx;
        logic [11:0] fy;
        logic [15:0] frame;
    } vt_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;
    logic stb0, stb1, stb2;

    logic hs0, vs0, de0, ls0, fs0, vbs0, fe0;
    logic hs1, vs1, de1, ls1, fs1, vbs1, fe1;
    logic hs2, vs2, de2, ls2, fs2, vbs2, fe2;
    logic [11:0] x0, y0, fx0, fy0, x1, y1, fx1, fy1, x2, y2, fx2, fy2;
    logic [15:0] fr0, fr1, fr2;

    video_timing_gen dut0 (
        .i_clk(clk), .i_rst(rst0), .i_pix_stb(stb0),
        .o_hs(hs0), .o_vs(vs0), .o_de(de0), .o_x(x0), .o_y(y0),
        .o_line_start(ls0), .o_frame_start(fs0), .o_vblank_start(vbs0),
        .o_fetch(fe0), .o_fx(fx0), .o_fy(fy0), .o_frame(fr0)
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(0), .VS_POL(0), .LOOKAHEAD(3)
    ) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_pix_stb(stb1),
        .o_hs(hs1), .o_vs(vs1), .o_de(de1), .o_x(x1), .o_y(y1),
        .o_line_start(ls1), .o_frame_start(fs1), .o_vblank_start(vbs1),
        .o_fetch(fe1), .o_fx(fx1), .o_fy(fy1), .o_frame(fr1)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .LOOKAHEAD(13)
    ) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_pix_stb(stb2),
        .o_hs(hs2), .o_vs(vs2), .o_de(de2), .o_x(x2), .o_y(y2),
        .o_line_start(ls2), .o_frame_start(fs2), .o_vblank_start(vbs2),
        .o_fetch(fe2), .o_fx(fx2), .o_fy(fy2), .o_frame(fr2)
    );

    vt_t obs0, obs1, obs2;
    assign obs0 = {hs0, vs0, de0, x0, y0, ls0, fs0, vbs0, fe0, fx0, fy0, fr0};
    assign obs1 = {hs1, vs1, de1, x1, y1, ls1, fs1, vbs1, fe1, fx1, fy1, fr1};
    assign obs2 = {hs2, vs2, de2, x2, y2, ls2, fs2, vbs2, fe2, fx2, fy2, fr2};

    int checks = 0;
    int errors = 0;

    // Model state: strobes accepted since reset, and whether the last edge strobed.
    longint s0 = 0, s1 = 0, s2 = 0;
    bit     sl0 = 1'b0, sl1 = 1'b0, sl2 = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs: after s strobes the pixel index is (s-1) mod frame size,
    // the reset position being the last pixel of the frame.
    function automatic vt_t model(input longint ha, input longint hf, input longint hsw,
                                  input longint hb, input longint va, input longint vf,
                                  input longint vsw, input longint vb, input longint hp,
                                  input longint vp, input longint la, input longint s,
                                  input bit sl);
        vt_t    e;
        longint ht, vt, n, pos, h, v, q, fh, fv;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        n  = ht * vt;
        pos = (s == 0) ? (n - 1) : ((s - 1) % n);
        h = pos % ht;
        v = pos / ht;
        q  = (pos + la) % n;
        fh = q % ht;
        fv = q / ht;
        e.hs    = ((h >= ha + hf) && (h < ha + hf + hsw)) ? 1'(hp) : ~1'(hp);
        e.vs    = ((v >= va + vf) && (v < va + vf + vsw)) ? 1'(vp) : ~1'(vp);
        e.de    = (h < ha) && (v < va);
        e.x     = e.de ? 12'(h) : 12'd0;
        e.y     = e.de ? 12'(v) : 12'd0;
        e.ls    = sl && (h == 0) && (v < va);
        e.fs    = sl && (pos == 0);
        e.vbs   = sl && (h == 0) && (v == va);
        e.fetch = (fh < ha) && (fv < va);
        e.fx    = e.fetch ? 12'(fh) : 12'd0;
        e.fy    = e.fetch ? 12'(fv) : 12'd0;
        e.frame = (s == 0) ? 16'd0 : 16'((s - 1) / n + 1);
        return e;
    endfunction

    task automatic cmp(input string d, input vt_t o, input vt_t e);
        check_eq({d, ".hs"},    32'(o.hs),    32'(e.hs));
        check_eq({d, ".vs"},    32'(o.vs),    32'(e.vs));
        check_eq({d, ".de"},    32'(o.de),    32'(e.de));
        check_eq({d, ".x"},     32'(o.x),     32'(e.x));
        check_eq({d, ".y"},     32'(o.y),     32'(e.y));
        check_eq({d, ".ls"},    32'(o.ls),    32'(e.ls));
        check_eq({d, ".fs"},    32'(o.fs),    32'(e.fs));
        check_eq({d, ".vbs"},   32'(o.vbs),   32'(e.vbs));
        check_eq({d, ".fetch"}, 32'(o.fetch), 32'(e.fetch));
        check_eq({d, ".fx"},    32'(o.fx),    32'(e.fx));
        check_eq({d, ".fy"},    32'(o.fy),    32'(e.fy));
        check_eq({d, ".frame"}, 32'(o.frame), 32'(e.frame));
    endtask

    // One clock: advance the models with the inputs sampled at the edge, then compare.
    task automatic step();
        @(posedge clk);
        if (rst0) begin s0 = 0; sl0 = 1'b0; end
        else if (stb0) begin s0++; sl0 = 1'b1; end
        else sl0 = 1'b0;
        if (rst1) begin s1 = 0; sl1 = 1'b0; end
        else if (stb1) begin s1++; sl1 = 1'b1; end
        else sl1 = 1'b0;
        if (rst2) begin s2 = 0; sl2 = 1'b0; end
        else if (stb2) begin s2++; sl2 = 1'b1; end
        else sl2 = 1'b0;
        #1;
        cmp("dut0", obs0, model(640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 0, s0, sl0));
        cmp("dut1", obs1, model(16, 2, 3, 3, 6, 1, 1, 2, 0, 0, 3, s1, sl1));
        cmp("dut2", obs2, model(8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 13, s2, sl2));
    endtask

    initial begin
        int hs_low;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        stb0 = 1'b0; stb1 = 1'b0; stb2 = 1'b0;
        repeat (2) step();
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        // Constant strobe: first line of the default mode plus many small frames.
        hs_low = 0;
        for (int i = 0; i < 2000; i++) begin
            stb0 = 1'b1; stb1 = 1'b1; stb2 = 1'b1;
            step();
            if (i < 800 && hs0 == 1'b0) hs_low++;
        end
        check_eq("dut0.hs_low_count_line0", 32'(hs_low), 32'd96);

        // Strobe every 4th cycle: pulses stay one cycle, levels hold.
        for (int i = 0; i < 1000; i++) begin
            stb0 = (i % 4 == 3); stb1 = (i % 4 == 3); stb2 = (i % 4 == 3);
            step();
        end

        // Random strobes with occasional independent resets.
        for (int i = 0; i < 20000; i++) begin
            stb0 = 1'($urandom_range(0, 1));
            stb1 = 1'($urandom_range(0, 1));
            stb2 = ($urandom_range(0, 3) != 0);
            rst0 = ($urandom_range(0, 499) == 0);
            rst1 = ($urandom_range(0, 299) == 0);
            rst2 = ($urandom_range(0, 299) == 0);
            step();
        end

        // Mid-line reset of the inverted-polarity instance, together with a strobe.
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        stb0 = 1'b1; stb1 = 1'b1; stb2 = 1'b1;
        repeat (5) step();
        rst2 = 1'b1;
        step();
        rst2 = 1'b0; stb2 = 1'b0;
        step();
        stb2 = 1'b1;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
